// File: rtl/surf_cin_tx.sv
// CIN transmitter: serializes 32-bit command words MSB nybble first onto a
// 4-bit bus, with word boundaries locked to the global sync and a training mode.
module surf_cin_tx #(
  parameter logic [31:0] TRAIN_PATTERN = 32'hA55A6996,
  parameter logic [31:0] IDLE_WORD     = 32'h00000000,
  parameter logic        CIN_INV       = 1'b0
) (
  input  logic        sysclk_i,
  input  logic        sysclk_rstn_i,
  input  logic        sync_i,
  input  logic        train_i,
  input  logic [31:0] cmd_tdata_i,
  input  logic        cmd_tvalid_i,
  output logic        cmd_tready_o,
  output logic [3:0]  cin_o,
  output logic        training_o,
  output logic        running_o,
  output logic        sync_err_o
);

  localparam logic [1:0] ST_WAIT_SYNC = 2'd0;
  localparam logic [1:0] ST_TRAIN     = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;
  localparam logic [3:0] INV4         = {4{CIN_INV}};

  logic [1:0]  state_r;
  logic [1:0]  next_state_s;
  logic [2:0]  nyb_cnt_r;
  logic [31:0] shift_r;
  logic [31:0] word_s;
  logic [3:0]  cin_r;
  logic        sync_err_r;
  logic        load_s;
  logic        misalign_s;

  // Load point, next state and the word selected for loading.
  always_comb begin
    load_s       = 1'b0;
    misalign_s   = 1'b0;
    next_state_s = state_r;
    word_s       = IDLE_WORD;
    case (state_r)
      ST_WAIT_SYNC: load_s = sync_i;
      ST_TRAIN, ST_RUN: begin
        load_s     = sync_i | (nyb_cnt_r == 3'd7);
        misalign_s = sync_i & (nyb_cnt_r != 3'd7);
      end
      default: load_s = sync_i;
    endcase
    if (load_s) begin
      next_state_s = train_i ? ST_TRAIN : ST_RUN;
    end else if (state_r == 2'd3) begin
      // Unreachable encoding falls back to waiting for sync.
      next_state_s = ST_WAIT_SYNC;
    end else begin
      next_state_s = state_r;
    end
    if (next_state_s == ST_TRAIN) begin
      word_s = TRAIN_PATTERN;
    end else if (cmd_tvalid_i) begin
      word_s = cmd_tdata_i;
    end else begin
      word_s = IDLE_WORD;
    end
  end

  assign cmd_tready_o = load_s & ~train_i;

  // State, nybble counter, shifter and output register.
  always_ff @(posedge sysclk_i) begin
    if (!sysclk_rstn_i) begin
      state_r    <= ST_WAIT_SYNC;
      nyb_cnt_r  <= 3'd0;
      shift_r    <= 32'h0000_0000;
      cin_r      <= INV4;
      sync_err_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      nyb_cnt_r <= sync_i ? 3'd0 : nyb_cnt_r + 3'd1;
      if (load_s) begin
        cin_r   <= word_s[31:28] ^ INV4;
        shift_r <= {word_s[27:0], 4'h0};
      end else if (state_r == ST_WAIT_SYNC) begin
        cin_r   <= INV4;
        shift_r <= 32'h0000_0000;
      end else begin
        cin_r   <= shift_r[31:28] ^ INV4;
        shift_r <= {shift_r[27:0], 4'h0};
      end
      if (misalign_s) begin
        sync_err_r <= 1'b1;
      end
    end
  end

  assign cin_o      = cin_r;
  assign sync_err_o = sync_err_r;
  assign training_o = (state_r == ST_TRAIN);
  assign running_o  = (state_r == ST_RUN);

endmodule

// File: tb/tb_surf_cin_tx.sv
// Self-checking bench for surf_cin_tx: a nybble-queue reference model drives
// expectations for a normal and an output-inverted instance.
module tb_surf_cin_tx;
  localparam logic [31:0] TRAIN_PATTERN = 32'hA55A6996;

  logic sysclk_i = 1'b0;
  always #5 sysclk_i = ~sysclk_i;

  logic rstn = 1'b0, sync = 1'b0, train = 1'b0, valid = 1'b0;
  logic [31:0] data = 32'h0;
  logic tready, tready_v, training, training_v, running, running_v, err, err_v;
  logic [3:0] cin, cin_v;

  surf_cin_tx dut (
    .sysclk_i(sysclk_i), .sysclk_rstn_i(rstn), .sync_i(sync), .train_i(train),
    .cmd_tdata_i(data), .cmd_tvalid_i(valid), .cmd_tready_o(tready),
    .cin_o(cin), .training_o(training), .running_o(running), .sync_err_o(err));

  surf_cin_tx #(.CIN_INV(1'b1)) dut_inv (
    .sysclk_i(sysclk_i), .sysclk_rstn_i(rstn), .sync_i(sync), .train_i(train),
    .cmd_tdata_i(data), .cmd_tvalid_i(valid), .cmd_tready_o(tready_v),
    .cin_o(cin_v), .training_o(training_v), .running_o(running_v), .sync_err_o(err_v));

  int n_chk = 0, n_fail = 0;

  // Reference model: mode 0 = waiting for sync, 1 = training, 2 = running
  int m_mode = 0, m_pos = 0;
  bit m_err = 1'b0;
  logic [3:0] m_q[$];
  logic [3:0] exp_cin = 4'h0;
  logic exp_tready;
  logic obs_tready, obs_tready_v, obs_trn, obs_run, obs_err;
  logic [3:0] obs_cin, obs_cin_v;

  task automatic cycle();
    bit load;
    logic [31:0] w;
    @(negedge sysclk_i);
    load = (m_mode == 0) ? sync : ((m_pos == 7) || sync);
    exp_tready = load && !train;
    obs_tready = tready;
    obs_tready_v = tready_v;
    @(posedge sysclk_i);
    if (!rstn) begin
      m_mode = 0; m_pos = 0; m_err = 1'b0; m_q.delete(); exp_cin = 4'h0;
    end else begin
      if (sync && m_mode != 0 && m_pos != 7) m_err = 1'b1;
      if (load) begin
        m_mode = train ? 1 : 2;
        w = (m_mode == 1) ? TRAIN_PATTERN : (valid ? data : 32'h0);
        m_q.delete();
        for (int k = 7; k >= 0; k--) m_q.push_back(w[k*4 +: 4]);
      end
      exp_cin = (m_q.size() > 0) ? m_q.pop_front() : 4'h0;
      m_pos = sync ? 0 : (m_pos + 1) % 8;
    end
    #1;
    obs_cin = cin; obs_cin_v = cin_v; obs_trn = training;
    obs_run = running; obs_err = err;
  endtask

  task automatic test_reset();
    rstn = 1'b0; sync = 1'b0; train = 1'b0; valid = 1'b1; data = $urandom;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_chk += 4;
      if (obs_cin !== 4'h0) begin n_fail++; $display("FAIL rst_cin got %h want 0", obs_cin); end
      if (obs_cin_v !== 4'hF) begin n_fail++; $display("FAIL rst_cin_inv got %h want f", obs_cin_v); end
      if ({obs_trn, obs_run} !== 2'b00) begin n_fail++; $display("FAIL rst_state got %b want 00", {obs_trn, obs_run}); end
      if (obs_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", obs_err); end
    end
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_chk += 4;
      if (obs_tready !== 1'b0) begin n_fail++; $display("FAIL nosync_tready got %b want 0", obs_tready); end
      if (obs_tready_v !== 1'b0) begin n_fail++; $display("FAIL nosync_tready_inv got %b want 0", obs_tready_v); end
      if (obs_cin !== 4'h0) begin n_fail++; $display("FAIL nosync_cin got %h want 0", obs_cin); end
      if (obs_run !== 1'b0) begin n_fail++; $display("FAIL nosync_running got %b want 0", obs_run); end
    end
  endtask

  task automatic test_train();
    logic [31:0] pat;
    int k;
    bit seen;
    pat = TRAIN_PATTERN; k = 0; seen = 1'b0;
    train = 1'b1; valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sync = (m_pos == 7);
      cycle();
      if (sync) seen = 1'b1;
      n_chk += 3;
      if (obs_cin !== exp_cin) begin n_fail++; $display("FAIL train_cin got %h want %h", obs_cin, exp_cin); end
      if (obs_tready !== 1'b0) begin n_fail++; $display("FAIL train_tready got %b want 0", obs_tready); end
      if (obs_trn !== (m_mode == 1)) begin n_fail++; $display("FAIL train_flag got %b want %0d", obs_trn, m_mode == 1); end
      if (seen) begin
        n_chk += 2;
        if (obs_cin !== pat[31 - 4*(k%8) -: 4]) begin n_fail++; $display("FAIL train_pat got %h want %h", obs_cin, pat[31 - 4*(k%8) -: 4]); end
        if (obs_trn !== 1'b1) begin n_fail++; $display("FAIL train_on got %b want 1", obs_trn); end
        k++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] got;
    int n_acc, n_got, n_rdy;
    got = 64'h0; n_acc = 0; n_got = 0; n_rdy = 0;
    train = 1'b0; valid = 1'b1; data = 32'h12345678;
    for (int i = 0; i < 60 && n_got < 16; i++) begin
      sync = (m_pos == 7);
      cycle();
      n_chk += 2;
      if (obs_cin !== exp_cin) begin n_fail++; $display("FAIL b2b_cin got %h want %h", obs_cin, exp_cin); end
      if (obs_tready !== exp_tready) begin n_fail++; $display("FAIL b2b_tready got %b want %b", obs_tready, exp_tready); end
      if (obs_tready) n_rdy++;
      if (obs_tready && valid) begin
        n_acc++;
        if (n_acc == 1) data = 32'hDEADBEEF;
        else begin valid = 1'b0; data = 32'h0; end
      end
      if (n_acc >= 1) begin got = {got[59:0], obs_cin}; n_got++; end
    end
    n_chk += 3;
    if (got !== 64'h12345678DEADBEEF) begin n_fail++; $display("FAIL b2b_seq got %h want 12345678deadbeef", got); end
    if (n_rdy != 2) begin n_fail++; $display("FAIL b2b_tready_count got %0d want 2", n_rdy); end
    if (obs_run !== 1'b1) begin n_fail++; $display("FAIL b2b_running got %b want 1", obs_run); end
  endtask

  task automatic test_idle_midword();
    int wait_n;
    logic [31:0] d;
    valid = 1'b0; data = 32'h0;
    for (int i = 0; i < 16 || m_pos != 3; i++) begin
      sync = (m_pos == 7);
      cycle();
      n_chk++;
      if (obs_cin !== 4'h0) begin n_fail++; $display("FAIL idle_cin got %h want 0", obs_cin); end
    end
    d = $urandom; valid = 1'b1; data = d; wait_n = 0;
    for (int i = 0; i < 12 && valid; i++) begin
      sync = (m_pos == 7);
      cycle();
      wait_n++;
      n_chk += 2;
      if (obs_cin !== exp_cin) begin n_fail++; $display("FAIL mid_cin got %h want %h", obs_cin, exp_cin); end
      if (obs_tready !== exp_tready) begin n_fail++; $display("FAIL mid_tready got %b want %b", obs_tready, exp_tready); end
      if (obs_tready) begin
        valid = 1'b0;
        n_chk++;
        if (obs_cin !== d[31:28]) begin n_fail++; $display("FAIL mid_first got %h want %h", obs_cin, d[31:28]); end
      end
    end
    n_chk++;
    if (wait_n != 5) begin n_fail++; $display("FAIL mid_accept_delay got %0d want 5", wait_n); end
    for (int i = 0; i < 8; i++) begin
      sync = (m_pos == 7);
      cycle();
      n_chk++;
      if (obs_cin !== exp_cin) begin n_fail++; $display("FAIL mid_tail got %h want %h", obs_cin, exp_cin); end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] d;
    for (int i = 0; i < 16 && m_pos != 3; i++) begin sync = (m_pos == 7); cycle(); end
    d = $urandom; sync = 1'b1; valid = 1'b1; data = d;
    cycle();
    n_chk += 3;
    if (obs_err !== 1'b1) begin n_fail++; $display("FAIL mis_err got %b want 1", obs_err); end
    if (obs_tready !== 1'b1) begin n_fail++; $display("FAIL mis_tready got %b want 1", obs_tready); end
    if (obs_cin !== d[31:28]) begin n_fail++; $display("FAIL mis_msb got %h want %h", obs_cin, d[31:28]); end
    valid = 1'b0; data = 32'h0;
    for (int i = 0; i < 24; i++) begin
      sync = (m_pos == 7);
      cycle();
      n_chk += 3;
      if (obs_err !== 1'b1) begin n_fail++; $display("FAIL mis_sticky got %b want 1", obs_err); end
      if (obs_cin !== exp_cin) begin n_fail++; $display("FAIL mis_cin got %h want %h", obs_cin, exp_cin); end
      if (obs_tready !== exp_tready) begin n_fail++; $display("FAIL mis_tready2 got %b want %b", obs_tready, exp_tready); end
    end
  endtask

  task automatic test_inv();
    logic [31:0] got;
    int n_got;
    got = 32'h0; n_got = 0;
    valid = 1'b1; data = 32'h0000000F;
    for (int i = 0; i < 30 && n_got < 8; i++) begin
      sync = (m_pos == 7);
      cycle();
      n_chk++;
      if (obs_cin_v !== ~exp_cin) begin n_fail++; $display("FAIL inv_cin got %h want %h", obs_cin_v, ~exp_cin); end
      if (obs_tready && valid) begin valid = 1'b0; data = 32'h0; n_got = 0; end
      if (!valid) begin got = {got[27:0], obs_cin_v}; n_got++; end
    end
    n_chk++;
    if (got !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL inv_seq got %h want fffffff0", got); end
  endtask

  task automatic test_reset_midword();
    valid = 1'b1; data = $urandom;
    for (int i = 0; i < 16 && m_pos != 4; i++) begin sync = (m_pos == 7); cycle(); end
    rstn = 1'b0; sync = 1'b0;
    cycle();
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      n_chk += 3;
      if (obs_tready !== 1'b0) begin n_fail++; $display("FAIL rmw_tready got %b want 0", obs_tready); end
      if (obs_cin !== 4'h0) begin n_fail++; $display("FAIL rmw_cin got %h want 0", obs_cin); end
      if (obs_err !== 1'b0) begin n_fail++; $display("FAIL rmw_err got %b want 0", obs_err); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rstn = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 39) == 0) train = ~train;
      sync = (m_pos == 7) || ($urandom_range(0, 59) == 0);
      if (!valid) begin valid = $urandom_range(0, 1); data = $urandom; end
      cycle();
      if (obs_tready && valid && rstn) valid = 1'b0;
      n_chk += 6;
      if (obs_cin !== exp_cin) begin n_fail++; $display("FAIL rnd_cin got %h want %h", obs_cin, exp_cin); end
      if (obs_cin_v !== ~exp_cin) begin n_fail++; $display("FAIL rnd_cin_inv got %h want %h", obs_cin_v, ~exp_cin); end
      if (obs_trn !== (m_mode == 1)) begin n_fail++; $display("FAIL rnd_training got %b want %0d", obs_trn, m_mode == 1); end
      if (obs_run !== (m_mode == 2)) begin n_fail++; $display("FAIL rnd_running got %b want %0d", obs_run, m_mode == 2); end
      if (obs_err !== m_err) begin n_fail++; $display("FAIL rnd_err got %b want %b", obs_err, m_err); end
      if (obs_tready !== exp_tready) begin n_fail++; $display("FAIL rnd_tready got %b want %b", obs_tready, exp_tready); end
    end
  endtask

  initial begin
    test_reset();
    test_train();
    test_back_to_back();
    test_idle_midword();
    test_misaligned();
    test_inv();
    test_reset_midword();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
